pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
Parametrised elastic pipeline register, the successor to the plain stall/flush flip-flop used between CPU pipeline stages. It chains STAGES skid-buffered register slices with a valid/ready handshake. Global flush and stall controls are retained. The block sits between producer and consumer stages of the rv64 pipeline, for example IF→ID or MEM→WB, and breaks both the data path and the ready path into registered form.

Parameters:
WIDTH, 64, payload width in bits.
STAGES, 1, number of chained slices (≥1); forward latency in cycles.
OCC_W, $clog2(2*STAGES+1), occupancy counter width (derived, not overridden).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-high.
flush  in  1  synchronous discard of all held entries.
stall  in  1  global freeze.
in_valid  in  1  producer has data.
in_ready  out  1  block accepts data this cycle.
in_data  in  WIDTH  payload.
out_valid  out  1  data available to consumer.
out_ready  in  1  consumer accepts.
out_data  out  WIDTH  payload of oldest entry.
occupancy  out  OCC_W  number of valid entries held (0..2*STAGES).
perf_stall_cnt  out  32  present only with PIPE_STAGE_PERF_EN.
perf_bubble_cnt  out  32  present only with PIPE_STAGE_PERF_EN.

Behaviour:
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Each slice has a main reg (data, v) and a skid reg (data, v). Slice k's input is slice k-1's output; slice 0 takes in_*; the last slice drives out_*.
- Slice ready = ~skid_v, taken from a register, so there is no combinational path from out_ready to in_ready. Slice valid = main_v.
- Slice update, on a non-stall, non-flush cycle:
  - Out transfer with skid_v: main←skid, skid_v←0. Any simultaneous in-transfer cannot occur, because ready was 0.
  - Out transfer without skid_v: main←input if in-transfer, else main_v←0.
  - No out transfer, in-transfer, main_v=0: main←input.
  - No out transfer, in-transfer, main_v=1: skid←input.
- in_ready = ~skid_v[0] & ~stall & ~flush.
- out_valid = main_v[STAGES-1] & ~stall.
- out_data = main data of the last slice. It holds its value when invalid.
- Latency: STAGES cycles from in-transfer to out_valid with out_ready held 1. Throughput is 1 beat/cycle sustained. Order is strictly FIFO.
- Capacity: 2*STAGES entries. When full, in_ready=0 until the consumer drains.
- stall=1: all state frozen. in_ready=0, out_valid=0, so no transfer occurs on either side. The consumer asserting out_ready during stall has no effect.
- flush=1: next edge clears all main_v/skid_v and zeroes all data regs. in_ready=0 in the flush cycle, so the beat presented then is dropped.
- Priority: rst > flush > stall > handshake. flush together with stall flushes.
- occupancy = popcount of all main_v and skid_v bits, computed combinationally from registers.
- Reset: all v=0, all data=0. Outputs after reset: out_valid=0, out_data=0, in_ready=1 (when stall=0 and flush=0), occupancy=0. Perf counters are 0.
- Reset mid-stream: all in-flight beats are lost. Nothing is emitted on the cycle after reset.

Optional Feature:
PIPE_STAGE_PERF_EN.
- Defined: perf_stall_cnt increments each cycle with stall=1. perf_bubble_cnt increments each cycle with out_ready=1 & out_valid=0 & stall=0. Both are 32-bit, wrap at 2^32-1→0, and are cleared by rst only (flush does not clear them).
- Undefined: both ports and counters are absent. Handshake behaviour is identical.

Test Plan:
1. STAGES=3, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles → out_data 0x11,0x22,0x33 on cycles 3,4,5 after the first accept; no gaps.
2. STAGES=2, out_ready=0, push continuously → in_ready drops after the 4th accept, occupancy=4. Raise out_ready → 4 beats emitted in order, then in_ready=1.
3. STAGES=2, fill with 3 beats, assert flush 1 cycle with in_valid=1 → next cycle occupancy=0, out_valid=0, out_data=0; the flush-cycle beat never appears.
4. Streaming 0xA0..0xA9, stall high for 3 cycles mid-stream → no transfers during stall, occupancy constant, order preserved, no duplicates or losses.
5. stall and flush high together with occupancy=2 → contents flushed, occupancy=0. rst asserted mid-stream → out_valid=0, occupancy=0 the next cycle.
6. With PIPE_STAGE_PERF_EN: 5 stall cycles plus 2 empty cycles with out_ready=1 → perf_stall_cnt=5, perf_bubble_cnt=2. Preload perf_stall_cnt=0xFFFFFFFF, one stall → wraps to 0.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline register: STAGES chained skid-buffered slices with valid/ready,
// global flush and stall. Define PIPE_STAGE_PERF_EN to add stall/bubble counters.
module pipe_stage_buf #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 1,
  parameter int unsigned OCC_W  = $clog2(2*STAGES+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_bubble_cnt
`endif
);

  logic [WIDTH-1:0]  main_d [STAGES];
  logic [WIDTH-1:0]  skid_d [STAGES];
  logic [WIDTH-1:0]  up_d   [STAGES];
  logic [STAGES-1:0] main_v;
  logic [STAGES-1:0] skid_v;
  logic [STAGES-1:0] up_xfer;
  logic [STAGES-1:0] dn_xfer;

  assign in_ready  = ~skid_v[0] & ~stall & ~flush;
  assign out_valid = main_v[STAGES-1] & ~stall;
  assign out_data  = main_d[STAGES-1];
  assign occupancy = OCC_W'($countones({main_v, skid_v}));

  // Inter-slice handshakes ignore stall/flush; the register update below is gated instead.
  for (genvar k = 0; k < STAGES; k++) begin : g_link
    if (k == 0) begin : g_head
      assign up_xfer[k] = in_valid & in_ready;
      assign up_d[k]    = in_data;
    end else begin : g_mid
      assign up_xfer[k] = main_v[k-1] & ~skid_v[k];
      assign up_d[k]    = main_d[k-1];
    end
    if (k == STAGES-1) begin : g_tail
      assign dn_xfer[k] = out_valid & out_ready;
    end else begin : g_inner
      assign dn_xfer[k] = main_v[k] & ~skid_v[k+1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_v <= '0;
      skid_v <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        main_d[k] <= '0;
        skid_d[k] <= '0;
      end
    end else if (!stall) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (dn_xfer[k]) begin
          if (skid_v[k]) begin
            main_d[k] <= skid_d[k];
            skid_v[k] <= 1'b0;
          end else if (up_xfer[k]) begin
            main_d[k] <= up_d[k];
          end else begin
            main_v[k] <= 1'b0;
          end
        end else if (up_xfer[k]) begin
          if (!main_v[k]) begin
            main_d[k] <= up_d[k];
            main_v[k] <= 1'b1;
          end else begin
            skid_d[k] <= up_d[k];
            skid_v[k] <= 1'b1;
          end
        end
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_bubble_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      if (stall) perf_stall_q <= perf_stall_q + 32'd1;
      if (out_ready && !out_valid && !stall) perf_bubble_q <= perf_bubble_q + 32'd1;
    end
  end

  assign perf_stall_cnt  = perf_stall_q;
  assign perf_bubble_cnt = perf_bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: scoreboard queues per instance (STAGES=2, STAGES=3)
// plus directed steps for fill, flush, stall, reset and optional perf counters.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst, flush, stall;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic [2:0]  occ2;
  logic        i3_valid, i3_ready, o3_valid, o3_ready;
  logic [63:0] i3_data, o3_data;
  logic [2:0]  occ3;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] ps2, pb2, ps3, pb3;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pops2  = 0;
  int pops3  = 0;
  logic [63:0] q2[$];
  logic [63:0] q3[$];
  int          q3c[$];

  pipe_stage_buf #(.WIDTH(64), .STAGES(2)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occ2)
`ifdef PIPE_STAGE_PERF_EN
    , .perf_stall_cnt(ps2), .perf_bubble_cnt(pb2)
`endif
  );

  pipe_stage_buf #(.WIDTH(64), .STAGES(3)) u3 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(i3_valid), .in_ready(i3_ready), .in_data(i3_data),
    .out_valid(o3_valid), .out_ready(o3_ready), .out_data(o3_data),
    .occupancy(occ3)
`ifdef PIPE_STAGE_PERF_EN
    , .perf_stall_cnt(ps3), .perf_bubble_cnt(pb3)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Scoreboards: occupancy must equal the number of beats taken but not yet delivered.
  always @(negedge clk) begin
    if (rst) begin
      q2.delete();
    end else begin
      check("occ2", {61'd0, occ2}, q2.size());
      if (out_valid && out_ready) begin
        check("out2_expected", q2.size() != 0, 1);
        if (q2.size() != 0) begin
          check("out2_data", out_data, q2.pop_front());
          pops2++;
        end
      end
      if (in_valid && in_ready) q2.push_back(in_data);
      if (flush) q2.delete();
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q3.delete();
      q3c.delete();
    end else begin
      check("occ3", {61'd0, occ3}, q3.size());
      if (o3_valid && o3_ready) begin
        check("out3_expected", q3.size() != 0, 1);
        if (q3.size() != 0) begin
          check("out3_data", o3_data, q3.pop_front());
          check("out3_latency", cyc - q3c.pop_front(), 3);
          pops3++;
        end
      end
      if (i3_valid && i3_ready) begin
        q3.push_back(i3_data);
        q3c.push_back(cyc);
      end
      if (flush) begin
        q3.delete();
        q3c.delete();
      end
    end
  end

  task automatic push2(input int n, input logic [63:0] base, input int budget, output int acc);
    acc = 0;
    for (int c = 0; c < budget && acc < n; c++) begin
      in_valid = 1'b1;
      in_data  = base + 64'(acc);
      sample();
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain2(input string tag, input int budget);
    out_ready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      sample();
      if (q2.size() == 0) break;
      step();
    end
    check(tag, q2.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int p0;
    logic [63:0] val;
    rst = 1'b1; flush = 1'b0; stall = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    i3_valid = 1'b0; i3_data = '0; o3_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    sample();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_occ", occ2, 0);
    check("rst_occ3", occ3, 0);
`ifdef PIPE_STAGE_PERF_EN
    check("rst_perf_stall", ps2, 0);
    check("rst_perf_bubble", pb2, 0);
`endif
    step();

    // STAGES=3 latency and back-to-back throughput
    for (int i = 0; i < 3; i++) begin
      i3_valid = 1'b1;
      i3_data  = 64'h11 * 64'(i + 1);
      sample();
      check("t1_in_ready", i3_ready, 1);
      step();
    end
    i3_valid = 1'b0;
    for (int c = 0; c < 12 && pops3 < 3; c++) begin
      sample();
      step();
    end
    check("t1_beats_out", pops3, 3);

    // Fill to capacity with consumer blocked, then drain
    out_ready = 1'b0;
    push2(8, 64'h100, 8, acc);
    check("t2_accepted", acc, 4);
    sample();
    check("t2_in_ready_full", in_ready, 0);
    check("t2_occ_full", occ2, 4);
    step();
    p0 = pops2;
    drain2("t2_drain", 20);
    check("t2_beats_out", pops2 - p0, 4);
    check("t2_in_ready_empty", in_ready, 1);
    step();

    // Flush with a beat presented in the flush cycle
    out_ready = 1'b0;
    push2(3, 64'h200, 10, acc);
    check("t3_accepted", acc, 3);
    flush = 1'b1; in_valid = 1'b1; in_data = 64'hDEAD;
    sample();
    check("t3_in_ready_flush", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    sample();
    check("t3_occ", occ2, 0);
    check("t3_out_valid", out_valid, 0);
    check("t3_out_data", out_data, 0);
    step();
    out_ready = 1'b1;
    p0 = pops2;
    repeat (4) begin
      sample();
      step();
    end
    check("t3_nothing_out", pops2 - p0, 0);

    // Streaming with a 3-cycle stall mid-stream
    out_ready = 1'b1;
    val = 64'hA0;
    p0  = pops2;
    for (int c = 0; c < 25; c++) begin
      stall    = (c >= 4 && c < 7);
      in_valid = (val <= 64'hA9);
      in_data  = val;
      sample();
      if (stall) begin
        check("t4_stall_in_ready", in_ready, 0);
        check("t4_stall_out_valid", out_valid, 0);
      end
      if (in_valid && in_ready) val++;
      step();
    end
    stall = 1'b0; in_valid = 1'b0;
    check("t4_all_sent", val, 64'hAA);
    drain2("t4_drain", 10);
    check("t4_beats_out", pops2 - p0, 10);
    step();

    // Flush together with stall
    out_ready = 1'b0;
    push2(2, 64'h300, 10, acc);
    check("t5_accepted", acc, 2);
    stall = 1'b1; flush = 1'b1;
    sample();
    check("t5_in_ready", in_ready, 0);
    check("t5_out_valid", out_valid, 0);
    step();
    stall = 1'b0; flush = 1'b0;
    sample();
    check("t5_occ", occ2, 0);
    step();

    // Reset mid-stream
    out_ready = 1'b1;
    push2(3, 64'h400, 10, acc);
    rst = 1'b1; in_valid = 1'b1; in_data = 64'h4FF;
    step();
    rst = 1'b0; in_valid = 1'b0;
    sample();
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_occ", occ2, 0);
    step();
    p0 = pops2;
    repeat (4) begin
      sample();
      step();
    end
    check("t5_rst_nothing_out", pops2 - p0, 0);

`ifdef PIPE_STAGE_PERF_EN
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    stall = 1'b1;
    repeat (5) step();
    stall = 1'b0; out_ready = 1'b1;
    repeat (2) step();
    out_ready = 1'b0;
    sample();
    check("t6_perf_stall", ps2, 5);
    check("t6_perf_bubble", pb2, 2);
    step();
    u2.perf_stall_q = 32'hFFFF_FFFF;
    stall = 1'b1;
    step();
    stall = 1'b0;
    sample();
    check("t6_perf_wrap", ps2, 0);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
